// File: rtl/dmem_master.sv
// Initiator side of the data-RAM cs/we/addr/din -> dout/ack handshake.
// Latches CPU loads/stores, stalls the pipeline while busy, aborts on watchdog expiry.
module dmem_master #(
    parameter int unsigned TIMEOUT   = 15,
    parameter int unsigned CNT_WIDTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    output logic        cpu_err,
    output logic        mem_cs,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    input  logic [31:0] mem_dout,
    input  logic        mem_ack
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE, ERR} state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT - 1);

    state_t               state;
    logic [31:0]          a_q;
    logic [31:0]          d_q;
    logic [31:0]          rdata_q;
    logic                 we_q;
    logic                 cs_q;
    logic                 mem_we_q;
    logic                 err_q;
    logic [CNT_WIDTH-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            a_q      <= '0;
            d_q      <= '0;
            rdata_q  <= '0;
            we_q     <= 1'b0;
            cs_q     <= 1'b0;
            mem_we_q <= 1'b0;
            err_q    <= 1'b0;
            cnt      <= '0;
        end else begin
            err_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu_req) begin
                        a_q      <= cpu_addr;
                        d_q      <= cpu_wdata;
                        we_q     <= cpu_we;
                        cnt      <= '0;
                        cs_q     <= 1'b1;
                        mem_we_q <= cpu_we;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    // An ack in the final watchdog cycle still completes normally.
                    if (mem_ack) begin
                        if (!we_q) begin
                            rdata_q <= mem_dout;
                        end
                        cs_q     <= 1'b0;
                        mem_we_q <= 1'b0;
                        state    <= DONE;
                    end else if (cnt == CNT_LAST) begin
                        rdata_q  <= '0;
                        cs_q     <= 1'b0;
                        mem_we_q <= 1'b0;
                        err_q    <= 1'b1;
                        state    <= ERR;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Combinational in IDLE so the pipeline freezes in the acceptance cycle.
    assign cpu_stall = (state == IDLE) ? cpu_req : (state == BUSY);
    assign cpu_rdata = rdata_q;
    assign cpu_err   = err_q;
    assign mem_cs    = cs_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = a_q;
    assign mem_din   = d_q;

endmodule
